// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch
// Desc   : MIPS fetch stage - PC, IF/ID register, redirects, fetch exceptions
// Rev    : 1.0  initial release
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] EXC_VECTOR = 32'd64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    EXC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] epc_q, epc_d;

  logic        redirect;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Misalignment outranks the opcode check: a misaligned word is not trusted.
  always_comb begin
    redirect    = jump_taken | branch_taken;
    fault_cause = 2'd0;
    if (pc_q[1:0] != 2'b00) begin
      fault_cause = 2'd1;
    end else if (imem_instruction[31:26] == 6'b111111) begin
      fault_cause = 2'd2;
    end
    fault = (state_q == RUN) && !stall && !redirect && (fault_cause != 2'd0);
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    exc_valid_d     = 1'b0;
    exc_cause_d     = 2'd0;
    epc_d           = epc_q;

    case (state_q)
      BOOT, EXC: begin
        // Bubble cycle: PC held so the RUN cycle fetches from it.
        state_d      = RUN;
        ifid_instr_d = 32'd0;
        ifid_valid_d = 1'b0;
      end
      RUN: begin
        if (fault) begin
          state_d      = EXC;
          pc_d         = EXC_VECTOR;
          ifid_instr_d = 32'd0;
          ifid_valid_d = 1'b0;
          exc_valid_d  = 1'b1;
          exc_cause_d  = fault_cause;
          epc_d        = pc_q;
        end else if (redirect) begin
          pc_d         = jump_taken ? jump_target : branch_target;
          ifid_instr_d = 32'd0;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d            = pc_plus4;
          ifid_instr_d    = flush ? 32'd0 : imem_instruction;
          ifid_pc_plus4_d = pc_plus4;
          ifid_valid_d    = !flush;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      ifid_instr_q    <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
      exc_valid_q     <= 1'b0;
      exc_cause_q     <= 2'd0;
      epc_q           <= 32'd0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      exc_valid_q     <= exc_valid_d;
      exc_cause_q     <= exc_cause_d;
      epc_q           <= epc_d;
    end
  end

  assign imem_pc           = pc_q;
  assign if_id_instruction = ifid_instr_q;
  assign if_id_pc_plus4    = ifid_pc_plus4_q;
  assign if_id_valid       = ifid_valid_q;
  assign exc_valid         = exc_valid_q;
  assign exc_cause         = exc_cause_q;
  assign epc               = epc_q;

endmodule
`default_nettype wire
